// File: rtl/iob_eth_rx_sfd.sv
// MII receive front-end: preamble/SFD hunt, nibble-to-byte assembly, frame error flags.
// Optional frame statistics counters are enabled with `define ETH_RX_STATS_EN.
module iob_eth_rx_sfd #(
  parameter int MIN_PREAMBLE = 2,
  parameter int MAX_PREAMBLE = 15,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518
) (
  input  logic        rst,
  input  logic        RX_CLK,
  input  logic        RX_DV,
  input  logic        RX_ER,
  input  logic [3:0]  RX_DATA,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        sof,
  output logic        eof,
  output logic        frame_err,
  output logic [10:0] byte_cnt
`ifdef ETH_RX_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
`endif
);

  localparam logic [4:0]  MAX_PRE_C = 5'(MAX_PREAMBLE);
  localparam logic [3:0]  MIN_PRE_C = 4'(MIN_PREAMBLE);
  localparam logic [10:0] MIN_FR_C  = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_FR_C  = 11'(MAX_FRAME);

  typedef enum logic [2:0] {IDLE, PRE, LO, HI, OVF, DROP} state_t;

  state_t     state;
  logic [1:0] rst_sync;
  logic       rst_i;
  logic       armed;
  logic       err;
  logic       first;
  logic [3:0] pcnt;
  logic [3:0] lo_nib;

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  always_ff @(posedge RX_CLK or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      armed      <= 1'b0;
      err        <= 1'b0;
      first      <= 1'b0;
      pcnt       <= 4'd0;
      lo_nib     <= 4'd0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      frame_err  <= 1'b0;
      byte_cnt   <= 11'd0;
    end else begin
      byte_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      if (!RX_DV) armed <= 1'b1;
      case (state)
        IDLE: begin
          // Until a gap has been seen we may be mid-frame, so stay deaf.
          if (armed && RX_DV) begin
            if (RX_DATA == 4'h5) begin
              state <= PRE;
              pcnt  <= 4'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PRE: begin
          if (!RX_DV) begin
            state <= IDLE;
          end else if (RX_ER) begin
            state <= DROP;
          end else if (RX_DATA == 4'h5) begin
            if ({1'b0, pcnt} + 5'd1 > MAX_PRE_C) state <= DROP;
            else if (pcnt != 4'hF)                pcnt  <= pcnt + 4'd1;
          end else if (RX_DATA == 4'hD && pcnt >= MIN_PRE_C) begin
            state    <= LO;
            err      <= 1'b0;
            byte_cnt <= 11'd0;
            first    <= 1'b1;
          end else begin
            state <= DROP;
          end
        end
        LO: begin
          if (RX_DV) begin
            lo_nib <= RX_DATA;
            err    <= err | RX_ER;
            state  <= HI;
          end else begin
            eof       <= 1'b1;
            frame_err <= err || (byte_cnt < MIN_FR_C);
            state     <= IDLE;
          end
        end
        HI: begin
          if (RX_DV) begin
            byte_data  <= {RX_DATA, lo_nib};
            byte_valid <= 1'b1;
            sof        <= first;
            first      <= 1'b0;
            byte_cnt   <= byte_cnt + 11'd1;
            err        <= err | RX_ER;
            state      <= (byte_cnt + 11'd1 == MAX_FR_C) ? OVF : LO;
          end else begin
            // Dribble nibble: the half byte is discarded.
            eof       <= 1'b1;
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        OVF: begin
          eof       <= 1'b1;
          frame_err <= 1'b1;
          state     <= RX_DV ? DROP : IDLE;
        end
        DROP: begin
          if (!RX_DV) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_RX_STATS_EN
  state_t last_state;
  logic   drop_ent;

  // Overlength frames are already counted by their eof, so only hunt failures count here.
  assign drop_ent = (state == DROP) && (last_state == IDLE || last_state == PRE);

  always_ff @(posedge RX_CLK or posedge rst_i) begin
    if (rst_i) begin
      last_state <= IDLE;
      frames_ok  <= 16'd0;
      frames_bad <= 16'd0;
    end else begin
      last_state <= state;
      if (stats_clr) begin
        frames_ok  <= 16'd0;
        frames_bad <= 16'd0;
      end else begin
        if (eof && !frame_err && frames_ok != 16'hFFFF)
          frames_ok <= frames_ok + 16'd1;
        if (((eof && frame_err) || drop_ent) && frames_bad != 16'hFFFF)
          frames_bad <= frames_bad + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_iob_eth_rx_sfd.sv
// Directed bench for iob_eth_rx_sfd: a frame-level model predicts bytes and eof status,
// and a negedge process compares every output strobe against it.
`timescale 1ns/1ps
module tb_iob_eth_rx_sfd;
  localparam int MINPRE = 2;
  localparam int MAXPRE = 15;
  localparam int MINF   = 64;
  localparam int MAXF   = 1518;

  logic        RX_CLK = 1'b0;
  logic        rst;
  logic        RX_DV;
  logic        RX_ER;
  logic [3:0]  RX_DATA;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        sof;
  logic        eof;
  logic        frame_err;
  logic [10:0] byte_cnt;
`ifdef ETH_RX_STATS_EN
  logic        stats_clr;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;
`endif

  iob_eth_rx_sfd dut (
    .rst(rst), .RX_CLK(RX_CLK), .RX_DV(RX_DV), .RX_ER(RX_ER), .RX_DATA(RX_DATA),
    .byte_data(byte_data), .byte_valid(byte_valid), .sof(sof), .eof(eof),
    .frame_err(frame_err), .byte_cnt(byte_cnt)
`ifdef ETH_RX_STATS_EN
    , .stats_clr(stats_clr), .frames_ok(frames_ok), .frames_bad(frames_bad)
`endif
  );

  always #5 RX_CLK = ~RX_CLK;

  int checks = 0;
  int passed = 0;
  int nbv = 0;
  int neof = 0;
  int m_ok = 0;
  int m_bad = 0;
  bit ignore = 1'b0;

  logic [3:0]  tx_nib[$];
  bit          tx_er[$];
  logic [8:0]  exp_b[$];   // {sof, byte}
  logic [11:0] exp_e[$];   // {frame_err, byte_cnt}
  logic [8:0]  eb;
  logic [11:0] ee;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge RX_CLK) begin
    if (!ignore) begin
      if (sof && !byte_valid) chk("sof_without_byte", 1, 0);
      if (byte_valid) begin
        nbv++;
        if (exp_b.size() == 0) chk("unexpected_byte_valid", {24'd0, byte_data}, 0);
        else begin
          eb = exp_b.pop_front();
          chk("byte_sof_data", {23'd0, sof, byte_data}, {23'd0, eb});
        end
      end
      if (eof) begin
        neof++;
        chk("eof_with_byte_valid", byte_valid, 0);
        chk("bytes_left_at_eof", exp_b.size(), 0);
        if (exp_e.size() == 0) chk("unexpected_eof", 1, 0);
        else begin
          ee = exp_e.pop_front();
          chk("eof_status", {20'd0, frame_err, byte_cnt}, {20'd0, ee});
        end
      end
    end
  end

  task automatic clr_tx();
    tx_nib.delete();
    tx_er.delete();
  endtask

  task automatic add(input logic [3:0] d, input bit er);
    tx_nib.push_back(d);
    tx_er.push_back(er);
  endtask

  task automatic add_pre(input int n);
    repeat (n) add(4'h5, 1'b0);
    add(4'hD, 1'b0);
  endtask

  task automatic add_bytes(input int start, input int cnt, input int er_at);
    logic [7:0] b;
    for (int k = 0; k < cnt; k++) begin
      b = 8'(start + k);
      add(b[3:0], k == er_at);
      add(b[7:4], 1'b0);
    end
  endtask

  // Frame-level prediction straight from the receive rules.
  task automatic model_frame();
    int n, s, m, full;
    bit err, bad;
    n = 0;
    while (n < tx_nib.size() && tx_nib[n] == 4'h5) n++;
    if (n > MAXPRE) begin m_bad++; return; end
    if (n == tx_nib.size()) return;
    if (n == 0 || tx_nib[n] != 4'hD || n < MINPRE) begin m_bad++; return; end
    s = n + 1;
    m = tx_nib.size() - s;
    full = m / 2;
    err = 1'b0;
    if (full >= MAXF) begin
      full = MAXF;
      m = 2 * MAXF;
    end
    for (int j = 0; j < m; j++) err |= tx_er[s + j];
    for (int k = 0; k < full; k++)
      exp_b.push_back({k == 0, tx_nib[s + 2*k + 1], tx_nib[s + 2*k]});
    bad = err || (m % 2 == 1) || (full < MINF) || (full == MAXF);
    exp_e.push_back({bad, 11'(full)});
    if (bad) m_bad++; else m_ok++;
  endtask

  task automatic nib(input logic [3:0] d, input logic er);
    @(posedge RX_CLK); #1;
    RX_DV = 1'b1; RX_DATA = d; RX_ER = er;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge RX_CLK); #1;
      RX_DV = 1'b0; RX_ER = 1'b0; RX_DATA = 4'h0;
    end
  endtask

  task automatic send(input string name, input bit lit_eof, input bit lit_err,
                      input int lit_cnt, input int lit_nbv);
    int nbv0;
    nbv0 = nbv;
    model_frame();
    foreach (tx_nib[i]) nib(tx_nib[i], tx_er[i]);
    idle(1);
    @(posedge RX_CLK);
    @(negedge RX_CLK);
    chk({name, " eof_after_dv_low"}, eof, lit_eof);
    if (lit_eof) chk({name, " frame_err"}, frame_err, lit_err);
    chk({name, " byte_cnt"}, byte_cnt, lit_cnt);
    idle(4);
    @(negedge RX_CLK);
    chk({name, " model_drained"}, exp_b.size() + exp_e.size(), 0);
    chk({name, " byte_valid_count"}, nbv - nbv0, lit_nbv);
  endtask

  logic [3:0] rseq [20] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'h5, 4'h5, 4'h5, 4'hD, 4'hD,
                            4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'h3, 4'h5};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbv0, neof0;
    rst = 1'b1; RX_DV = 1'b0; RX_ER = 1'b0; RX_DATA = 4'h0;
`ifdef ETH_RX_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge RX_CLK);
    @(negedge RX_CLK);
    chk("reset byte_data", byte_data, 0);
    chk("reset byte_valid", byte_valid, 0);
    chk("reset sof", sof, 0);
    chk("reset eof", eof, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset byte_cnt", byte_cnt, 0);
`ifdef ETH_RX_STATS_EN
    chk("reset frames_ok", frames_ok, 0);
    chk("reset frames_bad", frames_bad, 0);
`endif
    @(posedge RX_CLK); #1 rst = 1'b0;
    idle(5);

    clr_tx(); add_pre(7); add_bytes(0, 64, -1);
    send("clean64", 1, 0, 64, 64);

    // Reset in the middle of a payload full of 5/D nibbles.
    ignore = 1'b1;
    clr_tx(); add_pre(7); add_bytes(0, 2, -1);
    foreach (tx_nib[i]) nib(tx_nib[i], 1'b0);
    nbv0 = nbv; neof0 = neof;
    for (int i = 0; i < 20; i++) begin
      nib(rseq[i], 1'b0);
      if (i == 0) begin rst = 1'b1; #2 ignore = 1'b0; end
      if (i == 3) rst = 1'b0;
    end
    idle(6);
    @(negedge RX_CLK);
    chk("rst_mid no bytes", nbv - nbv0, 0);
    chk("rst_mid no eof", neof - neof0, 0);
    chk("rst_mid byte_cnt", byte_cnt, 0);
    m_ok = 0; m_bad = 0;
    clr_tx(); add_pre(7); add_bytes(8'h40, 64, -1);
    send("post_rst", 1, 0, 64, 64);

    clr_tx(); add_pre(7); add_bytes(0, 64, 10);
    send("rx_er_b10", 1, 1, 64, 64);

    clr_tx(); add_pre(7); add_bytes(0, 64, -1); add(4'h7, 1'b0);
    send("dribble", 1, 1, 64, 64);

    clr_tx(); add_pre(1); add_bytes(0, 8, -1);
    send("pre1", 0, 0, 64, 0);
    clr_tx(); add_pre(16); add_bytes(0, 8, -1);
    send("pre16", 0, 0, 64, 0);
    clr_tx(); add(4'hA, 1'b0); add_pre(7); add_bytes(0, 8, -1);
    send("bad_start", 0, 0, 64, 0);
    clr_tx(); add_pre(7); add_bytes(8'h80, 64, -1);
    send("after_bad", 1, 0, 64, 64);

    clr_tx(); add_pre(7); add_bytes(0, 1600, -1);
    send("overlength", 0, 0, 1518, 1518);

    clr_tx(); add_pre(7); add_bytes(8'h10, 20, -1);
    send("short20", 1, 1, 20, 20);

    clr_tx(); add_pre(7);
    send("sfd_only", 1, 1, 0, 0);

    clr_tx(); add_pre(2); add_bytes(8'hC0, 64, -1);
    send("pre2", 1, 0, 64, 64);
    clr_tx(); add_pre(15); add_bytes(8'h05, 65, -1);
    send("pre15", 1, 0, 65, 65);

`ifdef ETH_RX_STATS_EN
    chk("frames_ok", frames_ok, m_ok);
    chk("frames_bad", frames_bad, m_bad);
    chk("frames_ok literal", frames_ok, 4);
    chk("frames_bad literal", frames_bad, 8);
    @(posedge RX_CLK); #1 stats_clr = 1'b1;
    @(posedge RX_CLK); #1 stats_clr = 1'b0;
    @(negedge RX_CLK);
    chk("stats_clr ok", frames_ok, 0);
    chk("stats_clr bad", frames_bad, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
